// File: rtl/ppg_pp_extract.sv
// Per-window peak-to-peak extraction for red/IR PPG channels.
// Each closed window emits {red_pp, ir_pp}, or flags a low signal if the IR swing is too small.
module ppg_pp_extract #(
    parameter int WIN_LEN = 100,
    parameter int MIN_PP  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [17:0] red_data,
    input  logic [17:0] ir_data,
    input  logic        sample_valid,
    output logic [35:0] spodata,
    output logic        spodata_de,
    output logic        low_signal
);

    typedef enum logic {IDLE = 1'b0, ACQ = 1'b1} state_t;

    localparam logic [9:0]  WIN_LAST = 10'(WIN_LEN - 1);
    localparam logic [17:0] MIN_PP_V = 18'(MIN_PP);

    state_t      state_q, state_d;
    logic        acq;

    logic [9:0]  cnt_q, cnt_d;
    logic [17:0] red_max_q, red_max_d, red_min_q, red_min_d;
    logic [17:0] ir_max_q, ir_max_d, ir_min_q, ir_min_d;
    logic [35:0] spodata_q, spodata_d;
    logic        spodata_de_q, spodata_de_d;
    logic        low_signal_q, low_signal_d;

    logic        accept, first, close;
    logic [17:0] red_max_n, red_min_n, ir_max_n, ir_min_n;
    logic [17:0] red_pp, ir_pp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            red_max_q    <= '0;
            red_min_q    <= '0;
            ir_max_q     <= '0;
            ir_min_q     <= '0;
            spodata_q    <= '0;
            spodata_de_q <= 1'b0;
            low_signal_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            red_max_q    <= red_max_d;
            red_min_q    <= red_min_d;
            ir_max_q     <= ir_max_d;
            ir_min_q     <= ir_min_d;
            spodata_q    <= spodata_d;
            spodata_de_q <= spodata_de_d;
            low_signal_q <= low_signal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = ACQ;
            ACQ:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acq = (state_q == ACQ);
    end

    // A sample counts only while acquiring and still enabled in the same cycle.
    always_comb begin
        accept    = acq && enable && sample_valid;
        first     = (cnt_q == 10'd0);
        close     = accept && (cnt_q == WIN_LAST);

        red_max_n = (first || (red_data > red_max_q)) ? red_data : red_max_q;
        red_min_n = (first || (red_data < red_min_q)) ? red_data : red_min_q;
        ir_max_n  = (first || (ir_data  > ir_max_q))  ? ir_data  : ir_max_q;
        ir_min_n  = (first || (ir_data  < ir_min_q))  ? ir_data  : ir_min_q;

        red_pp    = red_max_n - red_min_n;
        ir_pp     = ir_max_n  - ir_min_n;
    end

    always_comb begin
        cnt_d        = cnt_q;
        red_max_d    = red_max_q;
        red_min_d    = red_min_q;
        ir_max_d     = ir_max_q;
        ir_min_d     = ir_min_q;
        spodata_d    = spodata_q;
        spodata_de_d = 1'b0;
        low_signal_d = 1'b0;

        // Leaving ACQ discards any partial window; IDLE keeps the trackers cleared.
        if (!acq) begin
            cnt_d     = '0;
            red_max_d = '0;
            red_min_d = '0;
            ir_max_d  = '0;
            ir_min_d  = '0;
        end else if (accept) begin
            cnt_d     = close ? 10'd0 : cnt_q + 10'd1;
            red_max_d = red_max_n;
            red_min_d = red_min_n;
            ir_max_d  = ir_max_n;
            ir_min_d  = ir_min_n;
        end

        if (close) begin
            if (ir_pp >= MIN_PP_V) begin
                spodata_d    = {red_pp, ir_pp};
                spodata_de_d = 1'b1;
            end else begin
                low_signal_d = 1'b1;
            end
        end
    end

    assign spodata    = spodata_q;
    assign spodata_de = spodata_de_q;
    assign low_signal = low_signal_q;

endmodule
